// File: rtl/branch_pkg.sv
// Shared types and constants for the branch sequencing controller.
// The saturating counter step lives here so the table and any checker agree on it.
package branch_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REDIRECT = 2'd1,
    SQUASH   = 2'd2
  } ctrl_state_e;

  typedef logic [1:0] bht_ctr_t;

  localparam bht_ctr_t    BHT_RESET_VAL = 2'b01;
  localparam bht_ctr_t    CTR_MAX       = 2'b11;
  localparam bht_ctr_t    CTR_MIN       = 2'b00;
  localparam logic [31:0] PC_STEP       = 32'd4;

  function automatic bht_ctr_t ctr_next(input bht_ctr_t ctr, input logic taken);
    bht_ctr_t res;
    if (taken) begin
      res = (ctr == CTR_MAX) ? CTR_MAX : ctr + 2'd1;
    end else begin
      res = (ctr == CTR_MIN) ? CTR_MIN : ctr - 2'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/bht_table.sv
// Branch history table: 2-bit saturating counters with one combinational read
// port and one saturating-update write port; reads return the pre-write value.
module bht_table
  import branch_pkg::*;
#(
  parameter int  ENTRIES = 16,
  localparam int IDX_W   = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [1:0]       rd_ctr,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_taken
);

  bht_ctr_t table_r [ENTRIES];

  // Counter storage: reset to weak-not-taken, saturating step on each resolution.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        table_r[i] <= BHT_RESET_VAL;
      end
    end else if (wr_en) begin
      table_r[wr_idx] <= ctr_next(table_r[wr_idx], wr_taken);
    end
  end

  assign rd_ctr = table_r[rd_idx];

endmodule

// File: rtl/branch_predict_ctrl.sv
// Branch sequencing controller: ID-stage prediction, EX-stage resolution,
// registered fetch redirect / flush generation and branch statistics.
module branch_predict_ctrl
  import branch_pkg::*;
#(
  parameter int  BHT_ENTRIES = 16,
  localparam int BHT_IDX_W   = $clog2(BHT_ENTRIES)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_is_branch,
  input  logic [31:0] id_pc,
  input  logic [31:0] id_imm,
  input  logic        id_stall,
  output logic        id_pred_taken,
  input  logic        ex_is_branch,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_imm,
  input  logic        ex_pred_taken,
  input  logic        ex_branch_take,
  input  logic        ex_stall,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        flush_if,
  output logic        flush_id,
  output logic [31:0] branch_count,
  output logic [31:0] mispredict_count
);

  ctrl_state_e state_r, next_state_s;

  logic [1:0]  id_ctr_s;
  logic        resolve_s;
  logic        mispredict_s;
  logic        redirect_valid_r, redirect_valid_s;
  logic [31:0] redirect_pc_r, redirect_pc_s;
  logic        flush_if_r, flush_if_s;
  logic        flush_id_r, flush_id_s;
  logic [31:0] branch_count_r, branch_count_s;
  logic [31:0] mispredict_count_r, mispredict_count_s;

  bht_table #(
    .ENTRIES (BHT_ENTRIES)
  ) u_bht (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_idx   (id_pc[BHT_IDX_W+1:2]),
    .rd_ctr   (id_ctr_s),
    .wr_en    (resolve_s),
    .wr_idx   (ex_pc[BHT_IDX_W+1:2]),
    .wr_taken (ex_branch_take)
  );

  assign id_pred_taken = id_is_branch & id_ctr_s[1];
  // A stalled EX branch is only resolved on the cycle its stall drops.
  assign resolve_s     = ex_is_branch & ~ex_stall & (state_r == IDLE);
  assign mispredict_s  = resolve_s & (ex_branch_take != ex_pred_taken);

  // Next state and next registered redirect/flush values; EX mispredict beats ID prediction.
  always_comb begin
    next_state_s     = state_r;
    redirect_valid_s = 1'b0;
    redirect_pc_s    = redirect_pc_r;
    flush_if_s       = 1'b0;
    flush_id_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (mispredict_s) begin
          next_state_s     = REDIRECT;
          redirect_valid_s = 1'b1;
          redirect_pc_s    = ex_branch_take ? (ex_pc + ex_imm) : (ex_pc + PC_STEP);
          flush_if_s       = 1'b1;
          flush_id_s       = 1'b1;
        end else if (id_pred_taken && !id_stall) begin
          redirect_valid_s = 1'b1;
          redirect_pc_s    = id_pc + id_imm;
          flush_if_s       = 1'b1;
        end else begin
          next_state_s     = IDLE;
        end
      end
      REDIRECT: begin
        next_state_s = SQUASH;
        flush_id_s   = 1'b1;
      end
      SQUASH: begin
        next_state_s = IDLE;
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // Saturating statistics, stepped once per resolution event.
  always_comb begin
    branch_count_s     = branch_count_r;
    mispredict_count_s = mispredict_count_r;
    if (resolve_s) begin
      if (branch_count_r != 32'hFFFF_FFFF) begin
        branch_count_s = branch_count_r + 32'd1;
      end else begin
        branch_count_s = branch_count_r;
      end
      if (mispredict_s && (mispredict_count_r != 32'hFFFF_FFFF)) begin
        mispredict_count_s = mispredict_count_r + 32'd1;
      end else begin
        mispredict_count_s = mispredict_count_r;
      end
    end else begin
      branch_count_s     = branch_count_r;
      mispredict_count_s = mispredict_count_r;
    end
  end

  // State, output and statistics registers; reset abandons any redirect in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r            <= IDLE;
      redirect_valid_r   <= 1'b0;
      redirect_pc_r      <= 32'd0;
      flush_if_r         <= 1'b0;
      flush_id_r         <= 1'b0;
      branch_count_r     <= 32'd0;
      mispredict_count_r <= 32'd0;
    end else begin
      state_r            <= next_state_s;
      redirect_valid_r   <= redirect_valid_s;
      redirect_pc_r      <= redirect_pc_s;
      flush_if_r         <= flush_if_s;
      flush_id_r         <= flush_id_s;
      branch_count_r     <= branch_count_s;
      mispredict_count_r <= mispredict_count_s;
    end
  end

  assign redirect_valid   = redirect_valid_r;
  assign redirect_pc      = redirect_pc_r;
  assign flush_if         = flush_if_r;
  assign flush_id         = flush_id_r;
  assign branch_count     = branch_count_r;
  assign mispredict_count = mispredict_count_r;

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Self-checking bench for branch_predict_ctrl: expected registered outputs are
// queued per cycle as stimulus is driven and compared one cycle later.
module tb_branch_predict_ctrl;

  logic        clk;
  logic        rst_n;
  logic        id_is_branch;
  logic [31:0] id_pc;
  logic [31:0] id_imm;
  logic        id_stall;
  logic        id_pred_taken;
  logic        ex_is_branch;
  logic [31:0] ex_pc;
  logic [31:0] ex_imm;
  logic        ex_pred_taken;
  logic        ex_branch_take;
  logic        ex_stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        flush_if;
  logic        flush_id;
  logic [31:0] branch_count;
  logic [31:0] mispredict_count;

  typedef struct {
    string       tag;
    logic        rv;
    logic [31:0] pc;
    logic        fi;
    logic        fid;
    logic [31:0] bc;
    logic [31:0] mc;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  branch_predict_ctrl #(.BHT_ENTRIES(16)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .id_is_branch     (id_is_branch),
    .id_pc            (id_pc),
    .id_imm           (id_imm),
    .id_stall         (id_stall),
    .id_pred_taken    (id_pred_taken),
    .ex_is_branch     (ex_is_branch),
    .ex_pc            (ex_pc),
    .ex_imm           (ex_imm),
    .ex_pred_taken    (ex_pred_taken),
    .ex_branch_take   (ex_branch_take),
    .ex_stall         (ex_stall),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .flush_if         (flush_if),
    .flush_id         (flush_id),
    .branch_count     (branch_count),
    .mispredict_count (mispredict_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic clr_inputs;
    id_is_branch   = 1'b0;
    id_pc          = 32'd0;
    id_imm         = 32'd0;
    id_stall       = 1'b0;
    ex_is_branch   = 1'b0;
    ex_pc          = 32'd0;
    ex_imm         = 32'd0;
    ex_pred_taken  = 1'b0;
    ex_branch_take = 1'b0;
    ex_stall       = 1'b0;
  endtask

  task automatic set_ex(input logic [31:0] pc, input logic [31:0] imm,
                        input logic pred, input logic take);
    ex_is_branch   = 1'b1;
    ex_pc          = pc;
    ex_imm         = imm;
    ex_pred_taken  = pred;
    ex_branch_take = take;
  endtask

  task automatic exp_out(input string tag, input logic rv, input logic [31:0] pc,
                         input logic fi, input logic fid,
                         input logic [31:0] bc, input logic [31:0] mc);
    exp_t e;
    e.tag = tag; e.rv = rv; e.pc = pc; e.fi = fi; e.fid = fid; e.bc = bc; e.mc = mc;
    sb.push_back(e);
  endtask

  // Advance one clock and compare the registered outputs against the oldest expectation.
  task automatic tick;
    exp_t e;
    @(posedge clk);
    #1;
    n_vec++;
    if (sb.size() == 0) begin
      n_err++;
      $display("FAIL scoreboard_empty: got no expectation, required one per cycle");
    end else begin
      e = sb.pop_front();
      if (redirect_valid !== e.rv) begin
        n_err++;
        $display("FAIL %s.redirect_valid: got %0b want %0b", e.tag, redirect_valid, e.rv);
      end
      n_vec++;
      if (flush_if !== e.fi) begin
        n_err++;
        $display("FAIL %s.flush_if: got %0b want %0b", e.tag, flush_if, e.fi);
      end
      n_vec++;
      if (flush_id !== e.fid) begin
        n_err++;
        $display("FAIL %s.flush_id: got %0b want %0b", e.tag, flush_id, e.fid);
      end
      n_vec++;
      if (branch_count !== e.bc) begin
        n_err++;
        $display("FAIL %s.branch_count: got %0d want %0d", e.tag, branch_count, e.bc);
      end
      n_vec++;
      if (mispredict_count !== e.mc) begin
        n_err++;
        $display("FAIL %s.mispredict_count: got %0d want %0d", e.tag, mispredict_count, e.mc);
      end
      if (e.rv) begin
        n_vec++;
        if (redirect_pc !== e.pc) begin
          n_err++;
          $display("FAIL %s.redirect_pc: got %h want %h", e.tag, redirect_pc, e.pc);
        end
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    clr_inputs();
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if ({redirect_valid, flush_if, flush_id} !== 3'b000 || redirect_pc !== 32'd0 ||
        branch_count !== 32'd0 || mispredict_count !== 32'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got rv=%0b fi=%0b fid=%0b pc=%h bc=%0d mc=%0d want all 0",
               redirect_valid, flush_if, flush_id, redirect_pc, branch_count, mispredict_count);
    end
    rst_n = 1'b1;
    id_is_branch = 1'b1;
    id_pc = 32'h100;
    #1;
    n_vec++;
    if (id_pred_taken !== 1'b0) begin
      n_err++;
      $display("FAIL reset_pred: got %0b want 0 (weak not-taken)", id_pred_taken);
    end
    clr_inputs();
  endtask

  task automatic test_mispredict;
    test_reset();
    set_ex(32'h100, 32'h40, 1'b0, 1'b1);
    exp_out("misp_redirect", 1'b1, 32'h140, 1'b1, 1'b1, 32'd1, 32'd1);
    tick();
    clr_inputs();
    exp_out("misp_squash", 1'b0, 32'h0, 1'b0, 1'b1, 32'd1, 32'd1);
    tick();
    exp_out("misp_idle", 1'b0, 32'h0, 1'b0, 1'b0, 32'd1, 32'd1);
    tick();
    id_is_branch = 1'b1;
    id_pc = 32'h100;
    #1;
    n_vec++;
    if (id_pred_taken !== 1'b1) begin
      n_err++;
      $display("FAIL misp_bht_weak_taken: got %0b want 1", id_pred_taken);
    end
    clr_inputs();
  endtask

  task automatic test_predict_taken;
    test_reset();
    set_ex(32'h100, 32'h40, 1'b1, 1'b1);
    id_is_branch = 1'b1;
    id_pc = 32'h100;
    #1;
    n_vec++;
    if (id_pred_taken !== 1'b0) begin
      n_err++;
      $display("FAIL rdw_old_value: got %0b want 0", id_pred_taken);
    end
    exp_out("train1", 1'b0, 32'h0, 1'b0, 1'b0, 32'd1, 32'd0);
    tick();
    id_is_branch = 1'b0;
    exp_out("train2", 1'b0, 32'h0, 1'b0, 1'b0, 32'd2, 32'd0);
    tick();
    clr_inputs();
    id_is_branch = 1'b1;
    id_pc = 32'h100;
    id_imm = 32'h40;
    id_stall = 1'b1;
    #1;
    n_vec++;
    if (id_pred_taken !== 1'b1) begin
      n_err++;
      $display("FAIL pred_strong_taken: got %0b want 1", id_pred_taken);
    end
    exp_out("pred_stalled", 1'b0, 32'h0, 1'b0, 1'b0, 32'd2, 32'd0);
    tick();
    id_stall = 1'b0;
    exp_out("pred_redirect", 1'b1, 32'h140, 1'b1, 1'b0, 32'd2, 32'd0);
    tick();
    clr_inputs();
    exp_out("pred_pulse_end", 1'b0, 32'h0, 1'b0, 1'b0, 32'd2, 32'd0);
    tick();
  endtask

  task automatic test_not_taken;
    test_reset();
    set_ex(32'h200, 32'h10, 1'b0, 1'b0);
    exp_out("nt1", 1'b0, 32'h0, 1'b0, 1'b0, 32'd1, 32'd0);
    tick();
    exp_out("nt2", 1'b0, 32'h0, 1'b0, 1'b0, 32'd2, 32'd0);
    tick();
    set_ex(32'h200, 32'h10, 1'b0, 1'b1);
    exp_out("nt_then_taken", 1'b1, 32'h210, 1'b1, 1'b1, 32'd3, 32'd1);
    tick();
    clr_inputs();
    exp_out("nt_squash", 1'b0, 32'h0, 1'b0, 1'b1, 32'd3, 32'd1);
    tick();
    exp_out("nt_idle", 1'b0, 32'h0, 1'b0, 1'b0, 32'd3, 32'd1);
    tick();
    id_is_branch = 1'b1;
    id_pc = 32'h200;
    #1;
    n_vec++;
    if (id_pred_taken !== 1'b0) begin
      n_err++;
      $display("FAIL nt_saturated_at_00: got %0b want 0", id_pred_taken);
    end
    clr_inputs();
  endtask

  task automatic test_back_to_back;
    test_reset();
    set_ex(32'h308, 32'h20, 1'b1, 1'b1);
    exp_out("col_train", 1'b0, 32'h0, 1'b0, 1'b0, 32'd1, 32'd0);
    tick();
    set_ex(32'h300, 32'hFFFF_FFF8, 1'b0, 1'b1);
    id_is_branch = 1'b1;
    id_pc = 32'h308;
    id_imm = 32'h20;
    #1;
    n_vec++;
    if (id_pred_taken !== 1'b1) begin
      n_err++;
      $display("FAIL col_id_pred: got %0b want 1", id_pred_taken);
    end
    exp_out("col_ex_wins", 1'b1, 32'h2F8, 1'b1, 1'b1, 32'd2, 32'd1);
    tick();
    ex_is_branch = 1'b0;
    exp_out("col_redirect_state", 1'b0, 32'h0, 1'b0, 1'b1, 32'd2, 32'd1);
    tick();
    set_ex(32'h400, 32'h8, 1'b1, 1'b0);
    exp_out("col_squash_ignores", 1'b0, 32'h0, 1'b0, 1'b0, 32'd2, 32'd1);
    tick();
    clr_inputs();
    exp_out("col_idle", 1'b0, 32'h0, 1'b0, 1'b0, 32'd2, 32'd1);
    tick();
  endtask

  task automatic test_stall;
    test_reset();
    set_ex(32'h100, 32'h40, 1'b0, 1'b1);
    ex_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_out("stall_hold", 1'b0, 32'h0, 1'b0, 1'b0, 32'd0, 32'd0);
      tick();
    end
    ex_stall = 1'b0;
    exp_out("stall_release", 1'b1, 32'h140, 1'b1, 1'b1, 32'd1, 32'd1);
    tick();
    clr_inputs();
    exp_out("stall_squash", 1'b0, 32'h0, 1'b0, 1'b1, 32'd1, 32'd1);
    tick();
    exp_out("stall_idle", 1'b0, 32'h0, 1'b0, 1'b0, 32'd1, 32'd1);
    tick();
  endtask

  task automatic test_reset_mid_redirect;
    test_reset();
    set_ex(32'h100, 32'h40, 1'b1, 1'b1);
    exp_out("rm_train1", 1'b0, 32'h0, 1'b0, 1'b0, 32'd1, 32'd0);
    tick();
    exp_out("rm_train2", 1'b0, 32'h0, 1'b0, 1'b0, 32'd2, 32'd0);
    tick();
    set_ex(32'h104, 32'h20, 1'b0, 1'b1);
    exp_out("rm_redirect", 1'b1, 32'h124, 1'b1, 1'b1, 32'd3, 32'd1);
    tick();
    clr_inputs();
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({redirect_valid, flush_if, flush_id} !== 3'b000 || redirect_pc !== 32'd0 ||
        branch_count !== 32'd0 || mispredict_count !== 32'd0) begin
      n_err++;
      $display("FAIL rm_async_clear: got rv=%0b fi=%0b fid=%0b pc=%h bc=%0d mc=%0d want all 0",
               redirect_valid, flush_if, flush_id, redirect_pc, branch_count, mispredict_count);
    end
    id_is_branch = 1'b1;
    id_pc = 32'h100;
    #1;
    n_vec++;
    if (id_pred_taken !== 1'b0) begin
      n_err++;
      $display("FAIL rm_table_reinit: got %0b want 0", id_pred_taken);
    end
    clr_inputs();
    sb.delete();
    rst_n = 1'b1;
    exp_out("rm_after1", 1'b0, 32'h0, 1'b0, 1'b0, 32'd0, 32'd0);
    tick();
    exp_out("rm_after2", 1'b0, 32'h0, 1'b0, 1'b0, 32'd0, 32'd0);
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    clr_inputs();
    test_reset();
    test_mispredict();
    test_predict_taken();
    test_not_taken();
    test_back_to_back();
    test_stall();
    test_reset_mid_redirect();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/branch_predict_ctrl.md
Name: branch_predict_ctrl

Overview:
- Branch sequencing controller for the 5-stage RISC pipeline.
- Predicts conditional branches in ID from a small table of 2-bit saturating counters, and redirects fetch on predicted-taken.
- Resolves each branch in EX against the branch comparator's branch_take result; on mispredict it issues a registered PC redirect and pipeline flushes.
- Keeps branch and mispredict statistics.

Parameters:
- BHT_ENTRIES, 16, number of 2-bit counters; power of 2, 4..256.
- BHT_IDX_W, $clog2(BHT_ENTRIES), table index width (derived, not overridden).

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- id_is_branch  in  1  conditional branch decoded in ID
- id_pc  in  32  PC of ID instruction
- id_imm  in  32  sign-extended B-type immediate in ID
- id_stall  in  1  ID held this cycle
- id_pred_taken  out  1  prediction for ID branch (comb); pipelined to EX by the ID/EX register
- ex_is_branch  in  1  conditional branch in EX
- ex_pc  in  32  PC of EX instruction
- ex_imm  in  32  immediate of EX instruction
- ex_pred_taken  in  1  prediction carried with EX instruction
- ex_branch_take  in  1  comparator result for EX instruction
- ex_stall  in  1  EX held this cycle
- redirect_valid  out  1  load PC from redirect_pc
- redirect_pc  out  32  new fetch PC
- flush_if  out  1  squash IF/ID register
- flush_id  out  1  squash ID/EX register
- branch_count  out  32  resolved branches, saturating
- mispredict_count  out  32  mispredicts, saturating

Behaviour:
- Index: idx(pc) = pc[BHT_IDX_W+1:2].
- Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- Reset: all counters 01; state IDLE; redirect_valid, flush_if, flush_id = 0; redirect_pc = 0; both counts = 0. Reset mid-redirect abandons the redirect.
- Prediction (comb):
  - id_pred_taken = id_is_branch & bht[idx(id_pc)][1].
- Resolution event: ex_is_branch & !ex_stall & state==IDLE.
  - Mispredict = ex_branch_take != ex_pred_taken.
- FSM states: IDLE, REDIRECT, SQUASH.
- IDLE:
  - Mispredict -> REDIRECT at next edge. Register redirect_pc = ex_branch_take ? ex_pc+ex_imm : ex_pc+4 (32-bit wrap, no overflow detection).
  - Else, if id_pred_taken & !id_stall: assert redirect_valid=1, redirect_pc=id_pc+id_imm, flush_if=1 in the next cycle (registered, one-cycle pulse). State stays IDLE.
- REDIRECT (one cycle): outputs redirect_valid=1, flush_if=1, flush_id=1; -> SQUASH.
- SQUASH (one cycle):
  - Outputs flush_id=1, to kill the one wrong-path instruction that advanced during the registered-redirect latency.
  - EX inputs ignored; -> IDLE.
- Mispredict penalty: 3 cycles from resolution to the first correct-path instruction in ID.
- Simultaneous EX mispredict and ID predicted-taken: the EX event wins; the ID redirect is dropped.
- Any ID prediction redirect issued while not in IDLE is suppressed.
- Table update, on each resolution event: bht[idx(ex_pc)] increments on taken and decrements on not-taken, saturating at 11 and 00.
- Read-during-write at the same index: ID sees the old value; the new value is visible the next cycle.
- Counters: on a resolution event, branch_count += 1 and mispredict_count += mispredict. Both saturate at 32'hFFFF_FFFF.
- ex_stall high: no update and no count; the event is re-evaluated when the stall drops, exactly once per instruction.

Decomposition:
- Package branch_pkg:
  - typedef ctrl_state_e {IDLE, REDIRECT, SQUASH};
  - typedef bht_ctr_t logic[1:0];
  - constants BHT_RESET_VAL=2'b01, CTR_MAX=2'b11, CTR_MIN=2'b00, PC_STEP=32'd4.
- Sub-module bht_table: counter array with one comb read port, one saturating-update write port, and async reset init.
- The FSM, redirect and statistics stay in the top level.

Test Plan:
- Reset, then branch at ex_pc=0x100, imm=0x40, pred=0, take=1 -> next cycle redirect_valid=1, redirect_pc=0x140, flush_if=flush_id=1; following cycle flush_id=1 only; bht[0] becomes 10; mispredict_count=1, branch_count=1.
- Branch at 0x100 resolved taken twice -> bht[0]=11; next id_is_branch at id_pc=0x100, imm=0x40 -> id_pred_taken=1, next cycle redirect_pc=0x140, flush_if=1, flush_id=0.
- Correct not-taken prediction (pred=0, take=0, ex_pc=0x200) -> no redirect or flush; counter saturates 01 -> 00 -> 00; branch_count increments, mispredict_count unchanged.
- Same cycle: EX mispredict (ex_pc=0x300, imm=-8, take=1) and ID predicted-taken (id_pc=0x308) -> redirect_pc=0x2F8 only; no ID redirect follows.
- ex_stall=1 for 3 cycles with a mispredicting branch in EX -> no redirect or count; on stall release, a single redirect and counts +1.
- Assert rst_n low during REDIRECT -> all outputs 0 asynchronously; table back to 01; after release, state IDLE with no residual flush.
